sprite_compositor: RTL and testbench

//  Per-pixel front end for the sprite/board palette frame RAMs. Turns VGA DrawX/DrawY plus

---
 rtl/sprite_compositor.sv | 188 ++++++++++++++++++
 tb/tb_sprite_compositor.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_compositor.sv
// Per-pixel sprite/board compositor: generates frame-RAM read addresses from the
// VGA coordinate and object positions, carries hit/board tags alongside the RAM
// read latency, then picks the winning colour by priority and transparency.
// Also runs the Pac-Man mouth open/close animation.
module sprite_compositor #(
  parameter int unsigned BOARD_W  = 280,
  parameter int unsigned BOARD_H  = 310,
  parameter int unsigned SPR_SZ   = 16,
  parameter int unsigned RAM_LAT  = 2,
  parameter int unsigned ANIM_DIV = 8
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         pix_valid,
  input  logic         frame_start,
  input  logic [9:0]   DrawX,
  input  logic [9:0]   DrawY,
  input  logic [9:0]   pac_x,
  input  logic [9:0]   pac_y,
  input  logic [1:0]   pac_dir,
  input  logic         pac_moving,
  input  logic [39:0]  ghost_x,
  input  logic [39:0]  ghost_y,
  input  logic [3:0]   ghost_en,
  input  logic [9:0]   cherry_x,
  input  logic [9:0]   cherry_y,
  input  logic         cherry_en,
  output logic [18:0]  bg_addr,
  output logic [18:0]  pac_addr,
  output logic [75:0]  ghost_addr,
  output logic [18:0]  cherry_addr,
  input  logic [23:0]  bg_rgb,
  input  logic [23:0]  cherry_rgb,
  input  logic [191:0] pac_rgb,
  input  logic [95:0]  ghost_rgb,
  output logic [7:0]   Red,
  output logic [7:0]   Green,
  output logic [7:0]   Blue,
  output logic         rgb_valid,
  output logic         mouth_open
);

  // Object slots in priority order: 0 = Pac-Man, 1..4 = ghosts, 5 = cherry
  localparam int NumObj = 6;
  localparam int unsigned CntW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  typedef enum logic {StOpen, StClosed} anim_state_e;

  // Everything the output stage needs to know about a pixel, minus the colours
  typedef struct packed {
    logic [NumObj-1:0] hit;
    logic              board;
    logic              valid;
    logic [2:0]        k;
  } tag_t;

  anim_state_e       state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        dir_q;

  logic [9:0]        obj_x [NumObj];
  logic [9:0]        obj_y [NumObj];
  logic [NumObj-1:0] obj_en;
  logic [10:0]       dx_c [NumObj];
  logic [10:0]       dy_c [NumObj];
  logic [NumObj-1:0] hit_c;
  logic [18:0]       addr_c [NumObj];
  logic [18:0]       addr_q [NumObj];
  logic              in_board_c;
  logic [18:0]       bg_addr_c;
  tag_t              tag_a_c, tag_a_q, tag_o;
  tag_t              tag_pipe_q [RAM_LAT];
  logic [23:0]       col_c [NumObj];
  logic [23:0]       rgb_c;

  // Animation state, frame counter and latched direction
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StOpen;
      cnt_q   <= '0;
      dir_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (frame_start) dir_q <= pac_dir;
    end
  end

  // Mouth toggles once every ANIM_DIV frames while Pac-Man is moving
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (frame_start && pac_moving) begin
      if (cnt_q == CntW'(ANIM_DIV - 1)) begin
        cnt_d   = '0;
        state_d = (state_q == StOpen) ? StClosed : StOpen;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign mouth_open = (state_q == StOpen);

  // Gather object positions/enables into slot arrays
  always_comb begin
    obj_x[0]  = pac_x;
    obj_y[0]  = pac_y;
    obj_en[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      obj_x[i+1]  = ghost_x[10*i +: 10];
      obj_y[i+1]  = ghost_y[10*i +: 10];
      obj_en[i+1] = ghost_en[i];
    end
    obj_x[5]  = cherry_x;
    obj_y[5]  = cherry_y;
    obj_en[5] = cherry_en;
  end

  // Hit test and sprite address; 11-bit wrap keeps off-edge sprites from aliasing
  always_comb begin
    for (int i = 0; i < NumObj; i++) begin
      dx_c[i]   = {1'b0, DrawX} - {1'b0, obj_x[i]};
      dy_c[i]   = {1'b0, DrawY} - {1'b0, obj_y[i]};
      hit_c[i]  = pix_valid & obj_en[i] & (dx_c[i] < 11'(SPR_SZ)) & (dy_c[i] < 11'(SPR_SZ));
      addr_c[i] = hit_c[i] ? (19'(dy_c[i]) * 19'(SPR_SZ) + 19'(dx_c[i])) : '0;
    end
    in_board_c = pix_valid & (32'(DrawX) < BOARD_W) & (32'(DrawY) < BOARD_H);
    bg_addr_c  = in_board_c ? (19'(DrawY) * 19'(BOARD_W) + 19'(DrawX)) : '0;
    tag_a_c.hit   = hit_c;
    tag_a_c.board = in_board_c;
    tag_a_c.valid = pix_valid;
    // Image index uses the state before any update at this same edge
    tag_a_c.k     = {dir_q, state_q == StClosed};
  end

  // Stage A: registered RAM addresses plus the tag that travels with them
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NumObj; i++) addr_q[i] <= '0;
      bg_addr <= '0;
      tag_a_q <= '0;
    end else begin
      for (int i = 0; i < NumObj; i++) addr_q[i] <= addr_c[i];
      bg_addr <= bg_addr_c;
      tag_a_q <= tag_a_c;
    end
  end

  assign pac_addr    = addr_q[0];
  assign ghost_addr  = {addr_q[4], addr_q[3], addr_q[2], addr_q[1]};
  assign cherry_addr = addr_q[5];

  // Delay the tag to line up with colours returning from the frame RAMs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < RAM_LAT; i++) tag_pipe_q[i] <= '0;
    end else begin
      tag_pipe_q[0] <= tag_a_q;
      for (int unsigned i = 1; i < RAM_LAT; i++) tag_pipe_q[i] <= tag_pipe_q[i-1];
    end
  end

  assign tag_o = tag_pipe_q[RAM_LAT-1];

  // Priority select: lowest slot with a hit and a non-black colour wins over the board
  always_comb begin
    col_c[0] = pac_rgb[int'(tag_o.k)*24 +: 24];
    for (int i = 0; i < 4; i++) col_c[i+1] = ghost_rgb[24*i +: 24];
    col_c[5] = cherry_rgb;
    rgb_c = tag_o.board ? bg_rgb : '0;
    for (int i = NumObj - 1; i >= 0; i--) begin
      if (tag_o.hit[i] && (col_c[i] != '0)) rgb_c = col_c[i];
    end
  end

  // Registered VGA output
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      {Red, Green, Blue} <= '0;
      rgb_valid          <= 1'b0;
    end else begin
      {Red, Green, Blue} <= rgb_c;
      rgb_valid          <= tag_o.valid;
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: frame RAMs are modelled as a fixed 3-edge delay of
// per-object colours, expected pixels go into a scoreboard with their due cycle.
module tb_sprite_compositor;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic         pix_valid, frame_start;
  logic [9:0]   DrawX, DrawY, pac_x, pac_y, cherry_x, cherry_y;
  logic [1:0]   pac_dir;
  logic         pac_moving, cherry_en;
  logic [39:0]  ghost_x, ghost_y;
  logic [3:0]   ghost_en;
  logic [18:0]  bg_addr, pac_addr, cherry_addr;
  logic [75:0]  ghost_addr;
  logic [23:0]  bg_rgb, cherry_rgb;
  logic [191:0] pac_rgb;
  logic [95:0]  ghost_rgb;
  logic [7:0]   Red, Green, Blue;
  logic         rgb_valid, mouth_open;

  // Colour "contents" of each RAM, attached to the pixel that is driven with them
  logic [191:0] pac_col_pk;
  logic [95:0]  ghost_col_pk;
  logic [23:0]  cherry_col, bg_col;
  logic [335:0] base_cur, b1, b2, b3;

  always #5 Clk = ~Clk;

  sprite_compositor dut (
    .Clk(Clk), .Reset_n(Reset_n), .pix_valid(pix_valid), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY), .pac_x(pac_x), .pac_y(pac_y), .pac_dir(pac_dir),
    .pac_moving(pac_moving), .ghost_x(ghost_x), .ghost_y(ghost_y), .ghost_en(ghost_en),
    .cherry_x(cherry_x), .cherry_y(cherry_y), .cherry_en(cherry_en),
    .bg_addr(bg_addr), .pac_addr(pac_addr), .ghost_addr(ghost_addr),
    .cherry_addr(cherry_addr), .bg_rgb(bg_rgb), .cherry_rgb(cherry_rgb),
    .pac_rgb(pac_rgb), .ghost_rgb(ghost_rgb), .Red(Red), .Green(Green), .Blue(Blue),
    .rgb_valid(rgb_valid), .mouth_open(mouth_open)
  );

  // Inputs sampled at t+1, colour valid after t+3, consumed at t+4
  assign base_cur = {pac_col_pk, ghost_col_pk, cherry_col, bg_col};
  always @(posedge Clk) begin
    b1 <= base_cur;
    b2 <= b1;
    b3 <= b2;
  end
  assign pac_rgb    = b3[335:144];
  assign ghost_rgb  = b3[143:48];
  assign cherry_rgb = b3[47:24];
  assign bg_rgb     = b3[23:0];

  typedef struct {
    logic [23:0] rgb;
    int          due;
  } exp_t;

  typedef struct {
    logic        pv;
    logic [9:0]  x, y, px, py;
    logic [39:0] gx, gy;
    logic [3:0]  gen;
    logic [9:0]  cx, cy;
    logic        cen;
    logic [23:0] pcol;
    logic [95:0] gcol;
    logic [23:0] exp_rgb;
  } vec_t;

  localparam int NV = 14;
  localparam logic [23:0] Img0 = 24'h010101;
  localparam logic [23:0] Img5 = 24'h060606;

  exp_t sb[$];
  vec_t vecs[NV];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [23:0] rgb);
    exp_t e;
    e.rgb = rgb;
    e.due = cyc + 4;
    sb.push_back(e);
  endtask

  // One clock; then compare whatever the DUT shows against the scoreboard head
  task automatic tick();
    exp_t e;
    @(posedge Clk);
    @(negedge Clk);
    cyc++;
    if (rgb_valid) begin
      if (sb.size() == 0) begin
        chk("rgb_valid_unexpected", 128'(rgb_valid), 128'd0);
      end else begin
        e = sb.pop_front();
        chk("rgb", {Red, Green, Blue}, e.rgb);
        chk("latency", cyc, e.due);
      end
    end else begin
      chk("black_when_invalid", {Red, Green, Blue}, 128'd0);
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        chk("rgb_valid_missing", 128'(rgb_valid), 128'd1);
        void'(sb.pop_front());
      end
    end
  endtask

  // Independent address model from the current driven inputs
  task automatic model_addr(output logic [18:0] eb, output logic [113:0] eo);
    logic [9:0]  ox, oy;
    logic        en;
    logic [10:0] dx, dy;
    eb = '0;
    eo = '0;
    if (pix_valid && DrawX < 10'd280 && DrawY < 10'd310) eb = 19'(DrawY) * 19'd280 + 19'(DrawX);
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        ox = pac_x; oy = pac_y; en = 1'b1;
      end else if (i == 5) begin
        ox = cherry_x; oy = cherry_y; en = cherry_en;
      end else begin
        ox = ghost_x[10*(i-1) +: 10]; oy = ghost_y[10*(i-1) +: 10]; en = ghost_en[i-1];
      end
      dx = {1'b0, DrawX} - {1'b0, ox};
      dy = {1'b0, DrawY} - {1'b0, oy};
      if (pix_valid && en && dx < 11'd16 && dy < 11'd16) eo[19*i +: 19] = 19'({dy[3:0], dx[3:0]});
    end
  endtask

  function automatic vec_t dflt();
    vec_t v;
    v.pv = 1'b1; v.x = '0; v.y = '0; v.px = 10'd500; v.py = 10'd500;
    v.gx = {4{10'd600}}; v.gy = {4{10'd600}}; v.gen = '0;
    v.cx = 10'd700; v.cy = 10'd700; v.cen = 1'b0; v.pcol = 24'hFFFB01;
    v.gcol = {24'hFFB852, 24'h00FFFF, 24'hFFB8FF, 24'hFF2500};
    v.exp_rgb = '0;
    return v;
  endfunction

  task automatic drive_vec(input vec_t v);
    pix_valid = v.pv; DrawX = v.x; DrawY = v.y; pac_x = v.px; pac_y = v.py;
    ghost_x = v.gx; ghost_y = v.gy; ghost_en = v.gen;
    cherry_x = v.cx; cherry_y = v.cy; cherry_en = v.cen;
    ghost_col_pk = v.gcol;
  endtask

  task automatic pac_pixel(input logic pv);
    pix_valid = pv; DrawX = 10'd103; DrawY = 10'd52; pac_x = 10'd100; pac_y = 10'd50;
    ghost_en = '0; cherry_en = 1'b0;
  endtask

  task automatic pulse_frames(input int n);
    for (int j = 0; j < n; j++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
    end
  endtask

  initial begin
    logic [18:0]  eb;
    logic [113:0] eo;

    Reset_n = 1'b0; pix_valid = 1'b0; frame_start = 1'b0; pac_dir = '0; pac_moving = 1'b0;
    drive_vec(dflt());
    pix_valid = 1'b0;
    pac_col_pk = '0; cherry_col = 24'hDE0000; bg_col = 24'h2121DE;

    vecs[0] = dflt();  vecs[0].x = 103; vecs[0].y = 52; vecs[0].px = 100; vecs[0].py = 50;
    vecs[0].exp_rgb = 24'hFFFB01;
    vecs[1] = vecs[0]; vecs[1].pcol = '0; vecs[1].gx[9:0] = 100; vecs[1].gy[9:0] = 50;
    vecs[1].gen = 4'b0001; vecs[1].exp_rgb = 24'hFF2500;
    vecs[2] = vecs[1]; vecs[2].pcol = 24'hFFFB01; vecs[2].exp_rgb = 24'hFFFB01;
    vecs[3] = dflt();  vecs[3].x = 280; vecs[3].y = 0; vecs[3].exp_rgb = 24'h000000;
    vecs[4] = dflt();  vecs[4].x = 5; vecs[4].y = 2; vecs[4].exp_rgb = 24'h2121DE;
    vecs[5] = dflt();  vecs[5].x = 2; vecs[5].y = 3; vecs[5].gx[19:10] = 1020;
    vecs[5].gy[19:10] = 0; vecs[5].gen = 4'b0010; vecs[5].exp_rgb = 24'h2121DE;
    vecs[6] = dflt();  vecs[6].x = 103; vecs[6].y = 52; vecs[6].gx[9:0] = 100;
    vecs[6].gy[9:0] = 50; vecs[6].exp_rgb = 24'h2121DE;
    vecs[7] = dflt();  vecs[7].x = 215; vecs[7].y = 115; vecs[7].gx[39:20] = {10'd200, 10'd200};
    vecs[7].gy[39:20] = {10'd100, 10'd100}; vecs[7].gen = 4'b1100; vecs[7].exp_rgb = 24'h00FFFF;
    vecs[8] = dflt();  vecs[8].x = 216; vecs[8].y = 100; vecs[8].gx[39:30] = 200;
    vecs[8].gy[39:30] = 100; vecs[8].gen = 4'b1000; vecs[8].exp_rgb = 24'h2121DE;
    vecs[9] = dflt();  vecs[9].x = 10; vecs[9].y = 10; vecs[9].cx = 10; vecs[9].cy = 10;
    vecs[9].cen = 1'b1; vecs[9].exp_rgb = 24'hDE0000;
    vecs[10] = vecs[0]; vecs[10].pv = 1'b0;
    vecs[11] = dflt(); vecs[11].x = 300; vecs[11].y = 20; vecs[11].gx[39:30] = 295;
    vecs[11].gy[39:30] = 15; vecs[11].gen = 4'b1000; vecs[11].gcol[95:72] = '0;
    vecs[11].cx = 298; vecs[11].cy = 18; vecs[11].cen = 1'b1; vecs[11].exp_rgb = 24'hDE0000;
    vecs[12] = dflt(); vecs[12].x = 0; vecs[12].y = 310; vecs[12].px = 0; vecs[12].py = 300;
    vecs[12].exp_rgb = 24'hFFFB01;
    vecs[13] = dflt(); vecs[13].x = 279; vecs[13].y = 309; vecs[13].exp_rgb = 24'h2121DE;

    // Reset state
    tick();
    tick();
    chk("reset_rgb", {Red, Green, Blue}, 128'd0);
    chk("reset_rgb_valid", 128'(rgb_valid), 128'd0);
    chk("reset_mouth_open", 128'(mouth_open), 128'd1);
    chk("reset_bg_addr", bg_addr, 128'd0);
    Reset_n = 1'b1;

    // Table vectors streamed back to back; image 0 carries the vector colour
    for (int i = 0; i < NV; i++) begin
      drive_vec(vecs[i]);
      pac_col_pk = {{7{24'h123456}}, vecs[i].pcol};
      if (vecs[i].pv) push(vecs[i].exp_rgb);
      tick();
      model_addr(eb, eo);
      chk($sformatf("v%0d_bg_addr", i), bg_addr, eb);
      chk($sformatf("v%0d_spr_addr", i), {cherry_addr, ghost_addr, pac_addr}, eo);
      if (i == 0) chk("pac_addr_35", pac_addr, 128'd35);
      if (i == 3) chk("bg_addr_off_board", bg_addr, 128'd0);
      if (i == 4) chk("bg_addr_565", bg_addr, 128'd565);
      if (i == 13) chk("bg_addr_last", bg_addr, 128'd86799);
    end
    pix_valid = 1'b0;
    repeat (5) tick();
    chk("sb_drained_vectors", sb.size(), 128'd0);

    // Mouth animation: toggles on the 8th moving frame, holds when not moving
    pac_col_pk = {24'h080808, 24'h070707, 24'h060606, 24'h050505,
                  24'h040404, 24'h030303, 24'h020202, Img0};
    pac_moving = 1'b1;
    pac_dir = 2'd2;
    pulse_frames(7);
    chk("mouth_after_7", 128'(mouth_open), 128'd1);
    pulse_frames(1);
    chk("mouth_after_8", 128'(mouth_open), 128'd0);
    pac_moving = 1'b0;
    pulse_frames(8);
    chk("mouth_hold_not_moving", 128'(mouth_open), 128'd0);
    pac_pixel(1'b1);
    push(Img5);
    tick();
    pac_pixel(1'b0);
    repeat (5) tick();
    chk("sb_drained_k5", sb.size(), 128'd0);

    // frame_start with a pixel in the same cycle: that pixel keeps the old image
    pac_moving = 1'b1;
    pulse_frames(7);
    chk("mouth_before_toggle", 128'(mouth_open), 128'd0);
    pac_pixel(1'b1);
    frame_start = 1'b1;
    pac_dir = 2'd0;
    push(Img5);
    tick();
    frame_start = 1'b0;
    pac_dir = 2'd3;
    push(Img0);
    tick();
    push(Img0);
    tick();
    pac_pixel(1'b0);
    repeat (5) tick();
    chk("mouth_after_coincident", 128'(mouth_open), 128'd1);
    chk("sb_drained_coincident", sb.size(), 128'd0);

    // Reset with the pipe full of visible pixels
    pac_dir = 2'd2;
    pulse_frames(8);
    chk("mouth_closed_pre_reset", 128'(mouth_open), 128'd0);
    pac_pixel(1'b1);
    repeat (5) begin
      push(Img5);
      tick();
    end
    Reset_n = 1'b0;
    pac_pixel(1'b0);
    sb.delete();
    #1;
    chk("async_reset_rgb", {Red, Green, Blue}, 128'd0);
    chk("async_reset_rgb_valid", 128'(rgb_valid), 128'd0);
    chk("async_reset_mouth", 128'(mouth_open), 128'd1);
    chk("async_reset_pac_addr", pac_addr, 128'd0);
    tick();
    tick();
    Reset_n = 1'b1;
    repeat (6) tick();
    pac_moving = 1'b0;
    pac_pixel(1'b1);
    push(Img0);
    tick();
    pac_pixel(1'b0);
    repeat (5) tick();
    chk("sb_drained_after_reset", sb.size(), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
